// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Steps through a latched list of SPI commands on behalf of the bootstrap
// controller. Each run:
//   1. presents an init status word until the engine reports init-done;
//   2. drives each command in turn until the engine returns that step's
//      expected flag code;
//   3. retries a step a bounded number of times when it times out.
//
// Handshake: start_i is a request that is taken only while busy_o is low.
// Once taken, the run owns the tables until done_o (success) or error_o
// (failure). No further acknowledge is needed from the requester.
//
// Ports:
//   master_clk_i     clock, rising edge
//   master_rst_i     asynchronous active-high reset
//   start_i          run request, honoured only when idle
//   cmd_table_i      N_CMDS command words, step k at [k*CMD_W +: CMD_W]
//   flag_table_i     expected flag code per step, step k at [k*3 +: 3]
//   timeout_i        cycles per attempt, 0 disables the timeout
//   init_done_i      SPI/bootstrap init complete
//   spi_flagreg_i    flag code returned by the SPI engine
//   spi_data_o       command word to the SPI engine (all ones when not issuing)
//   spi_statusreg_o  status word to the SPI engine
//   step_o           current (or failing) step index
//   busy_o           high whenever a run is in progress
//   done_o           one-cycle success pulse
//   error_o          sticky failure flag, cleared by the next accepted start
//   state_dbg        registered FSM state, for observation only
module sd_cmd_sequencer #(
  parameter int          CMD_W       = 48,
  parameter int          N_CMDS      = 4,
  parameter int          STEP_W      = 2,
  parameter int          TIMEOUT_W   = 16,
  parameter int          MAX_RETRY   = 3,
  parameter logic [8:0]  STATUS_INIT = 9'b110100011,
  parameter logic [8:0]  STATUS_RUN  = 9'b110100111
) (
  input  logic                     master_clk_i,
  input  logic                     master_rst_i,
  input  logic                     start_i,
  input  logic [N_CMDS*CMD_W-1:0]  cmd_table_i,
  input  logic [N_CMDS*3-1:0]      flag_table_i,
  input  logic [TIMEOUT_W-1:0]     timeout_i,
  input  logic                     init_done_i,
  input  logic [2:0]               spi_flagreg_i,
  output logic [CMD_W-1:0]         spi_data_o,
  output logic [8:0]               spi_statusreg_o,
  output logic [STEP_W-1:0]        step_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               state_dbg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_RETRY = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [2:0]               state;
  logic [STEP_W-1:0]        step;
  logic [RETRY_W-1:0]       retry;
  logic [TIMEOUT_W-1:0]     timer;
  logic                     error;
  logic [N_CMDS*CMD_W-1:0]  cmd_q;
  logic [N_CMDS*3-1:0]      flag_q;
  logic [TIMEOUT_W-1:0]     timeout_q;

  logic [CMD_W-1:0]         cur_cmd;
  logic [2:0]               cur_flag;
  logic                     flag_match;
  logic                     last_step;
  logic                     timed_out;

  always_comb begin
    cur_cmd    = cmd_q[int'(step)*CMD_W +: CMD_W];
    cur_flag   = flag_q[int'(step)*3 +: 3];
    flag_match = (spi_flagreg_i == cur_flag);
    last_step  = (step == STEP_W'(N_CMDS - 1));
    // The timer counts ISSUE cycles already spent in this attempt, so the
    // attempt ends on the cycle where it reaches timeout-1.
    timed_out  = (timeout_q != '0) && (timer == timeout_q - TIMEOUT_W'(1));
  end

  always_ff @(posedge master_clk_i or posedge master_rst_i) begin
    if (master_rst_i) begin
      state     <= ST_IDLE;
      step      <= '0;
      retry     <= '0;
      timer     <= '0;
      error     <= 1'b0;
      cmd_q     <= '0;
      flag_q    <= '0;
      timeout_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cmd_q     <= cmd_table_i;
            flag_q    <= flag_table_i;
            timeout_q <= timeout_i;
            step      <= '0;
            retry     <= '0;
            timer     <= '0;
            error     <= 1'b0;
            state     <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (init_done_i) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // A match wins over a timeout landing on the same cycle.
          if (flag_match) begin
            if (last_step) begin
              state <= ST_DONE;
            end else begin
              step  <= step + STEP_W'(1);
              retry <= '0;
              timer <= '0;
            end
          end else if (timed_out) begin
            if (retry < RETRY_W'(MAX_RETRY)) begin
              retry <= retry + RETRY_W'(1);
              timer <= '0;
              state <= ST_RETRY;
            end else begin
              // Raised on entry so error_o is already visible in the FAIL cycle.
              error <= 1'b1;
              state <= ST_FAIL;
            end
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        ST_RETRY: state <= ST_ISSUE;
        ST_DONE:  state <= ST_IDLE;
        ST_FAIL:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state, step and error.
  always_comb begin
    spi_data_o      = '1;
    spi_statusreg_o = 9'd0;
    case (state)
      ST_INIT: spi_statusreg_o = STATUS_INIT;
      ST_ISSUE: begin
        spi_data_o      = cur_cmd;
        spi_statusreg_o = STATUS_RUN;
      end
      default: begin
        spi_data_o      = '1;
        spi_statusreg_o = 9'd0;
      end
    endcase
  end

  assign step_o    = step;
  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign error_o   = error;
  assign state_dbg = state;

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Parametrised SPI command sequencer that sits between the bootstrap control logic and the SPI engine. On start it presents an init status word, waits for the engine's init-done, then issues a programmable list of N_CMDS fixed-width commands. For each command it waits for a per-step expected flag code, with per-step timeout and bounded retry. It replaces hand-coded per-command state ladders and signals completion or failure to the bootstrap controller.

## Interface
- CMD_W, 48, width of one SPI command word
- N_CMDS, 4, number of commands in the sequence (1..2**STEP_W)
- STEP_W, 2, width of step index
- TIMEOUT_W, 16, width of timeout counter
- MAX_RETRY, 3, retries allowed per step after the first attempt
- STATUS_INIT, 9'b110100011, status word driven while waiting for init-done
- STATUS_RUN, 9'b110100111, status word driven while issuing commands
- master_clk_i  in  1  clock, all logic on rising edge
- master_rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request to run the sequence; honoured only in IDLE
- cmd_table_i  in  N_CMDS*CMD_W  command list, step k at bits [k*CMD_W +: CMD_W]
- flag_table_i  in  N_CMDS*3  expected spi_flagreg_i code per step, step k at [k*3 +: 3]
- timeout_i  in  TIMEOUT_W  cycles to wait per attempt; 0 disables timeout
- init_done_i  in  1  SPI/bootstrap init complete
- spi_flagreg_i  in  3  flag code from SPI engine
- spi_data_o  out  CMD_W  command word to SPI engine
- spi_statusreg_o  out  9  status word to SPI engine
- step_o  out  STEP_W  current step index
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on successful completion
- error_o  out  1  sticky failure flag

## Operation
- States: IDLE, INIT, ISSUE, RETRY, DONE, FAIL.
- Tables latched into internal registers when start_i is accepted. Input changes during a run have no effect.
- IDLE: spi_data_o all ones, spi_statusreg_o 0. start_i=1 -> INIT, latch tables, step=0, retry=0, timer=0, error_o cleared.
- INIT: spi_statusreg_o=STATUS_INIT, spi_data_o all ones. init_done_i=1 -> ISSUE. No timeout in INIT.
- ISSUE: spi_data_o=cmd[step], spi_statusreg_o=STATUS_RUN.
  - If spi_flagreg_i==flag[step] and step==N_CMDS-1 -> DONE.
  - Else if spi_flagreg_i==flag[step] -> step+1; retry=0; timer=0; stay ISSUE.
  - Else if timeout_i!=0 and timer==timeout_i-1: if retry<MAX_RETRY, retry+1, timer=0 -> RETRY; otherwise -> FAIL.
  - Else timer+1.
- RETRY: one cycle with spi_data_o all ones and spi_statusreg_o 0, so the engine sees a drop. Then -> ISSUE with the same step.
- DONE: done_o=1 for this cycle -> IDLE.
- FAIL: error_o set -> IDLE. error_o holds until the next accepted start_i or reset. step_o holds the failing step until the next start.
- start_i is ignored when busy_o=1.
- Match takes priority over timeout in the same cycle.

## Timing
- Reset (async) forces: state IDLE, step_o 0, busy_o 0, done_o 0, error_o 0, spi_data_o all ones, spi_statusreg_o 0, retry/timer 0.
- Reset mid-run aborts immediately, with no done_o or error_o.
- All outputs decode from registered state, step, and error. Each output changes one cycle after the edge that caused the transition.
- Start latency: start_i sampled at edge t. STATUS_INIT appears after t.
- Step advance: match sampled at edge t. cmd[step+1] appears after t, so each command is driven for at least 1 cycle.
- Timeout: per attempt, a step fails over after exactly timeout_i ISSUE cycles without a match.
- Worst-case failed step length is (MAX_RETRY+1)*timeout_i + MAX_RETRY cycles.
- done_o is asserted exactly 1 cycle after the final match edge and lasts 1 cycle. busy_o falls in the same cycle done_o falls.

## Test plan
- Nominal run: N_CMDS=2, cmds 48'h5800004200FF / 48'hFE8623220000, flags 3'b100 / 3'b101, timeout_i=0. Flags returned after 5 cycles each -> commands appear in order, step_o 0 then 1, done_o one pulse, spi_data_o back to 48'hFFFFFFFFFFFF.
- Init gating: init_done_i held low 20 cycles -> spi_statusreg_o=9'b110100011 throughout, spi_data_o all ones. Then init_done_i=1 -> next cycle STATUS_RUN and cmd[0].
- Timeout/retry recovery: timeout_i=8, flag withheld on step 0 for first attempt -> after 8 cycles one RETRY cycle (data all ones, status 0), cmd[0] re-issued. Correct flag then -> step 1, retry counter reset.
- Exhausted retries: timeout_i=4, MAX_RETRY=3, flag never matches -> FAIL after 4*4+3 ISSUE/RETRY cycles, error_o=1 sticky, step_o=0, no done_o. Next start_i clears error_o.
- Boundaries: match on the same cycle timer reaches timeout -> advance, not retry. start_i pulsed while busy -> ignored. cmd_table_i changed mid-run -> latched values still issued.
- Async reset asserted in ISSUE step 1, between clock edges -> all outputs at reset values before the next edge, no done_o or error_o.
